idct_2d: RTL and testbench
==========================

IDCT_2D -- requirements
Module: idct

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; low forces reset state immediately, release synchronised to clk.
REQ-003 start  input  1  request to transform the block currently on f_mem_flat; sampled on clk rising edge.
REQ-004 f_mem_flat  input  1024  64 signed 16-bit two's-complement DCT coefficients F[u][v]; element k=8u+v at bits [16k+15:16k]; u is the vertical frequency (row), v the horizontal frequency (column).
REQ-005 output_data_flat  output  512  64 unsigned 8-bit pixels p[x][y]; element k=8x+y at bits [8k+7:8k]; registered.
REQ-006 done  output  1  result-valid flag; registered.

Function
REQ-007 FSM states: IDLE, ROW, COL, FIN.
REQ-008 IDLE with start=1 at an edge: latch all 64 coefficients into an internal buffer, clear done, go to ROW; start=0 keeps IDLE.
REQ-009 ROW: one 8-point 1D IDCT per cycle over rows u=0..7, 8 cycles, results stored in a transpose buffer, then go to COL.
REQ-010 COL: one 8-point 1D IDCT per cycle over columns 0..7 of the transpose buffer, 8 cycles, then go to FIN.
REQ-011 FIN: write all 64 pixels to output_data_flat in the same edge, set done=1, return to IDLE.
REQ-012 Latency: done rises exactly 17 clock edges after the edge accepting start; output_data_flat changes only on that edge.
REQ-013 done stays 1 and output_data_flat holds until the next accepted start; done clears on the accepting edge, output_data_flat holds the old block until the new FIN.
REQ-014 start while in ROW, COL or FIN is ignored (no restart, no queueing); f_mem_flat changes after the accepting edge have no effect.
REQ-015 Transform: p[x][y] = sat255(round(s) + 128), s = 1/4 * sum over u,v of C(u)C(v)F[u][v]cos((2x+1)u*pi/16)cos((2y+1)v*pi/16), C(0)=1/sqrt2, else 1.
REQ-016 Cosine constants: signed Q12 (round(4096*value)); row-pass results kept at >=24 bits signed with >=8 fractional bits; no internal overflow for any 16-bit input.
REQ-017 Rounding: round half away from zero once, after the column pass; then add 128; saturate to 0 below 0 and to 255 above 255.
REQ-018 Accuracy: every pixel within +/-1 of the double-precision formula for any input; DC-only blocks with F[0][0] a multiple of 8 in [-1024,1016] are exact.

Reset
REQ-019 While rst=0: state IDLE, done=0, output_data_flat=all zeros, internal buffers cleared.
REQ-020 Reset asserted mid-operation aborts the transform; no done pulse follows release; the first start after release is accepted normally.

Verification
REQ-021 All-zero coefficients, start pulse -> after 17 edges done=1, all 64 pixels = 128.
REQ-022 F[0][0]=800, others 0 -> all pixels 228; F[0][0]=-1024 -> all 0; F[0][0]=1016 -> all 255.
REQ-023 F[0][0]=2000 (saturation) -> all 255; F[0][0]=-2000 -> all 0.
REQ-024 F[0][1]=100, others 0 -> row-constant pattern per REQ-015 (column y=0 = 128+round(0.25*sqrt2*... ) i.e. 128+17=145, y=7 = 111), all within +/-1.
REQ-025 Second start pulsed 5 cycles after the first -> ignored; done exactly once at edge 17; output_data_flat and done hold until the next start.
REQ-026 rst driven low at cycle 8 of a transform -> outputs zero immediately, no done after release; a fresh start then completes in 17 edges.

Source files
------------

// File: rtl/idct_2d_if.sv
// Handshake and data bus of the 8x8 2D IDCT block.
// The requester drives start and the coefficient block; the IDCT returns the
// pixel block and the result-valid flag.
interface idct_2d_if;
   logic          start;
   logic [1023:0] f_mem_flat;
   logic [511:0]  output_data_flat;
   logic          done;

   modport master (
      output start,
      output f_mem_flat,
      input  output_data_flat,
      input  done
   );

   modport slave (
      input  start,
      input  f_mem_flat,
      output output_data_flat,
      output done
   );
endinterface

// File: rtl/idct_2d.sv
// 8x8 two-dimensional IDCT, row-column decomposition.
// One 8-point 1D IDCT per clock: 8 row passes into a transpose buffer, then
// 8 column passes into a pixel buffer, then a single publish edge.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last finished block
// ROW   | row pass, coefficient row idx -> transpose buffer row idx
// COL   | column pass, transpose column idx -> pixel column idx
// FIN   | publish all 64 pixels and raise done
module idct_2d (
   input logic    clk,
   input logic    rst,
   idct_2d_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ROW, COL, FIN} state_t;

   state_t             state;
   logic [2:0]         idx;
   logic signed [15:0] f_buf [64];
   logic signed [25:0] t_buf [64];
   logic [7:0]         px_buf [64];
   logic signed [25:0] row_res [8];
   logic [7:0]         col_pix [8];

   // Basis weight C(j)/2 * cos((2i+1)j*pi/16) in Q12. The angle is folded
   // into the first quadrant so one 8-entry table covers every (i, j).
   function automatic logic signed [12:0] kc(input int i, input int j);
      int                 m;
      logic               neg;
      logic signed [12:0] mag;
      if (j == 0) return 13'sd1448;
      m = ((2 * i + 1) * j) % 32;
      if (m > 16) m = 32 - m;
      neg = 1'b0;
      if (m > 8) begin
         m   = 16 - m;
         neg = 1'b1;
      end
      case (m)
         1:       mag = 13'sd2009;
         2:       mag = 13'sd1892;
         3:       mag = 13'sd1703;
         4:       mag = 13'sd1448;
         5:       mag = 13'sd1138;
         6:       mag = 13'sd784;
         7:       mag = 13'sd400;
         default: mag = 13'sd0;
      endcase
      return neg ? -mag : mag;
   endfunction

   // Row pass on coefficient row idx; result kept in Q8 (26 bits covers the
   // worst-case 16-bit input without overflow).
   always_comb begin
      logic signed [31:0] acc;
      for (int y = 0; y < 8; y++) begin
         acc = '0;
         for (int v = 0; v < 8; v++)
            acc = acc + 32'(kc(y, v)) * 32'(f_buf[{idx, 3'(v)}]);
         row_res[y] = 26'(acc >>> 4);
      end
   end

   // Column pass on transpose column idx; the only rounding step (half away
   // from zero), then level shift and clamp to 8 bits.
   always_comb begin
      logic signed [47:0] acc;
      logic signed [47:0] mag;
      logic signed [47:0] rnd;
      logic signed [47:0] val;
      for (int x = 0; x < 8; x++) begin
         acc = '0;
         for (int u = 0; u < 8; u++)
            acc = acc + 48'(kc(x, u)) * 48'(t_buf[{3'(u), idx}]);
         mag = (acc < 0) ? -acc : acc;
         rnd = (mag + 48'sd524288) >>> 20;
         val = ((acc < 0) ? -rnd : rnd) + 48'sd128;
         col_pix[x] = '0;
         if (val < 0)
            col_pix[x] = 8'd0;
         else if (val > 48'sd255)
            col_pix[x] = 8'd255;
         else
            col_pix[x] = val[7:0];
      end
   end

   // Sequencer, buffers and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                <= IDLE;
         idx                  <= '0;
         bus.done             <= 1'b0;
         bus.output_data_flat <= '0;
         for (int k = 0; k < 64; k++) begin
            f_buf[k]  <= '0;
            t_buf[k]  <= '0;
            px_buf[k] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  for (int k = 0; k < 64; k++)
                     f_buf[k] <= bus.f_mem_flat[16 * k +: 16];
                  bus.done <= 1'b0;
                  idx      <= '0;
                  state    <= ROW;
               end
            end
            ROW: begin
               for (int y = 0; y < 8; y++)
                  t_buf[{idx, 3'(y)}] <= row_res[y];
               idx <= idx + 3'd1;
               if (idx == 3'd7) state <= COL;
            end
            COL: begin
               for (int x = 0; x < 8; x++)
                  px_buf[{3'(x), idx}] <= col_pix[x];
               idx <= idx + 3'd1;
               if (idx == 3'd7) state <= FIN;
            end
            FIN: begin
               for (int k = 0; k < 64; k++)
                  bus.output_data_flat[8 * k +: 8] <= px_buf[k];
               bus.done <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_idct_2d.sv
// Self-checking bench for idct_2d: table of directed coefficient blocks with
// hand-computed pixels, plus sequences for ignored restarts and mid-run reset.
module tb_idct_2d;
   logic clk = 1'b0;
   logic rst_n;

   idct_2d_if bus ();

   idct_2d dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // expv holds one byte per position (byte n = position n); by_x selects
   // whether the position is the row x or the column y of the pixel.
   typedef struct {
      logic signed [15:0] f00;
      logic signed [15:0] f01;
      logic signed [15:0] f10;
      logic [63:0]        expv;
      bit                 by_x;
      int                 tol;
   } vec_t;

   vec_t vecs [10];

   int          n_checks = 0;
   int          n_pass   = 0;
   int          lat;
   int          ndone;
   logic        prev;
   bit          held;
   logic [511:0] old;
   logic [511:0] snap;

   task automatic check_int(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: actual %0d required %0d", name, act, req);
   endtask

   task automatic check_pix(input string name, input logic [63:0] expv,
                            input bit by_x, input int tol);
      int bad = -1;
      int a, e, ba, be;
      ba = 0;
      be = 0;
      for (int x = 0; x < 8; x++)
         for (int y = 0; y < 8; y++) begin
            a = int'(bus.output_data_flat[8 * (8 * x + y) +: 8]);
            e = by_x ? int'(expv[8 * x +: 8]) : int'(expv[8 * y +: 8]);
            if (bad < 0 && (a - e > tol || e - a > tol)) begin
               bad = 8 * x + y;
               ba  = a;
               be  = e;
            end
         end
      n_checks++;
      if (bad < 0) n_pass++;
      else $display("FAIL %s: pixel %0d actual %0d required %0d (tol %0d)",
                    name, bad, ba, be, tol);
   endtask

   function automatic logic [1023:0] mk(input logic signed [15:0] f00,
                                        input logic signed [15:0] f01,
                                        input logic signed [15:0] f10);
      logic [1023:0] v;
      v          = '0;
      v[15:0]    = f00;
      v[31:16]   = f01;
      v[143:128] = f10;
      return v;
   endfunction

   // Pulse start for one edge, then count edges until done (bounded).
   task automatic run_block(input logic [1023:0] f, output int latency);
      @(negedge clk);
      bus.f_mem_flat = f;
      bus.start      = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      latency   = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            latency = n;
            break;
         end
      end
   endtask

   initial begin
      vecs[0] = '{16'sd0,     16'sd0,    16'sd0,   {8{8'd128}}, 1'b0, 0};
      vecs[1] = '{16'sd800,   16'sd0,    16'sd0,   {8{8'd228}}, 1'b0, 0};
      vecs[2] = '{-16'sd1024, 16'sd0,    16'sd0,   {8{8'd0}},   1'b0, 0};
      vecs[3] = '{16'sd1016,  16'sd0,    16'sd0,   {8{8'd255}}, 1'b0, 0};
      vecs[4] = '{16'sd2000,  16'sd0,    16'sd0,   {8{8'd255}}, 1'b0, 0};
      vecs[5] = '{-16'sd2000, 16'sd0,    16'sd0,   {8{8'd0}},   1'b0, 0};
      vecs[6] = '{16'sd0,     16'sd100,  16'sd0,
                  {8'd111, 8'd113, 8'd118, 8'd125, 8'd131, 8'd138, 8'd143, 8'd145}, 1'b0, 1};
      vecs[7] = '{16'sd0,     -16'sd100, 16'sd0,
                  {8'd145, 8'd143, 8'd138, 8'd131, 8'd125, 8'd118, 8'd113, 8'd111}, 1'b0, 1};
      vecs[8] = '{16'sd800,   16'sd100,  16'sd0,
                  {8'd211, 8'd213, 8'd218, 8'd225, 8'd231, 8'd238, 8'd243, 8'd245}, 1'b0, 1};
      vecs[9] = '{16'sd0,     16'sd0,    16'sd100,
                  {8'd111, 8'd113, 8'd118, 8'd125, 8'd131, 8'd138, 8'd143, 8'd145}, 1'b1, 1};

      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.f_mem_flat = '0;
      repeat (3) @(posedge clk);
      #1;
      check_int("reset_done", int'(bus.done), 0);
      check_int("reset_out_zero", int'(bus.output_data_flat == '0), 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 10; i++) begin
         run_block(mk(vecs[i].f00, vecs[i].f01, vecs[i].f10), lat);
         check_int($sformatf("vec%0d_latency", i), lat, 17);
         check_pix($sformatf("vec%0d_pixels", i), vecs[i].expv, vecs[i].by_x, vecs[i].tol);
      end

      // Restarts during ROW and FIN plus input changes after acceptance are ignored.
      old = bus.output_data_flat;
      @(negedge clk);
      bus.f_mem_flat = mk(16'sd800, 16'sd0, 16'sd0);
      bus.start      = 1'b1;
      @(posedge clk);
      #1;
      check_int("restart_done_clears", int'(bus.done), 0);
      lat   = -1;
      ndone = 0;
      prev  = 1'b0;
      held  = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         bus.start = (n == 5 || n == 17);
         if (n == 2) bus.f_mem_flat = mk(-16'sd2000, 16'sd0, 16'sd0);
         @(posedge clk);
         #1;
         if (bus.done && !prev) begin
            ndone++;
            if (lat < 0) begin
               lat  = n;
               snap = bus.output_data_flat;
            end
         end
         if (lat < 0 && bus.output_data_flat !== old) held = 1'b0;
         prev = bus.done;
      end
      bus.start = 1'b0;
      check_int("ignore_latency", lat, 17);
      check_int("ignore_done_count", ndone, 1);
      check_int("old_out_held", int'(held), 1);
      check_pix("ignore_pixels", {8{8'd228}}, 1'b0, 0);
      check_int("hold_done", int'(bus.done), 1);
      check_int("hold_out", int'(bus.output_data_flat === snap), 1);

      // Reset in the middle of a transform.
      @(negedge clk);
      bus.f_mem_flat = mk(16'sd1016, 16'sd0, 16'sd0);
      bus.start      = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_int("midrst_done", int'(bus.done), 0);
      check_int("midrst_out_zero", int'(bus.output_data_flat == '0), 1);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      check_int("midrst_no_done", ndone, 0);
      run_block(mk(16'sd800, 16'sd100, 16'sd0), lat);
      check_int("after_rst_latency", lat, 17);
      check_pix("after_rst_pixels", vecs[8].expv, 1'b0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
